// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS31 definitions for the generator and the RX monitor.
//   PRBS31_TAP_A / PRBS31_TAP_B : polynomial x^31 + x^28 + 1
//   prbs31_step32(prev)          : next 32-bit word, MSB-first bit order
//   lane_mask(vldb)              : bit mask of valid byte lanes 0..vldb
//   mon_state_t                  : monitor lock FSM states
package prbs_pkg;

    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } mon_state_t;

    // Bit stream position p sits at s[63-p]; the previous word occupies
    // positions 0..31 (MSB first). Each new bit is b[p-31] ^ b[p-28]. Bits
    // that fold back onto bits produced earlier in this word flatten to at most
    // three XOR inputs of prev, so the result is a single shallow XOR level.
    function automatic logic [31:0] prbs31_step32(input logic [31:0] prev);
        logic [63:0] s;
        s = {prev, 32'h0000_0000};
        for (int p = 32; p < 64; p++) begin
            s[63 - p] = s[63 - p + PRBS31_TAP_A] ^ s[63 - p + PRBS31_TAP_B];
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] vldb);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = (k <= int'(vldb)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs_rx_monitor_sat_counter.sv
// sat_counter: W-bit saturating up-counter.
//   clk  : clock
//   srst : synchronous active-high reset
//   inc  : count up by one (held at all-ones once reached)
//   clr  : synchronous clear, wins over inc
//   q    : registered count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/prbs_rx_monitor.sv
// prbs_rx_monitor: frame-aware PRBS31 checker on the MAC RX user stream.
//   rx_user_clk_i / rx_user_rst_i : clock, synchronous active-high reset
//   rx_data_i, rx_vldb_i, rx_valid_i, rx_last_i, rx_user_i : RX beat stream
//   clear_i          : zero all counters (lock state untouched)
//   lock_o, err_o    : lock status, one-cycle errored-word pulse while locked
//   frame_cnt_o, word_cnt_o, err_word_cnt_o, bad_frame_cnt_o : saturating counters
// The first beat of each frame reseeds the predictor; later beats are checked.
module prbs_rx_monitor
    import prbs_pkg::*;
#(
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_BAD  = 4
) (
    input  logic        rx_user_clk_i,
    input  logic        rx_user_rst_i,
    input  logic [31:0] rx_data_i,
    input  logic [1:0]  rx_vldb_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic        rx_user_i,
    input  logic        clear_i,
    output logic        lock_o,
    output logic        err_o,
    output logic [31:0] frame_cnt_o,
    output logic [31:0] word_cnt_o,
    output logic [31:0] err_word_cnt_o,
    output logic [15:0] bad_frame_cnt_o
);

    mon_state_t  state_reg, state_next;
    logic [7:0]  good_cnt_reg, good_cnt_next;
    logic [3:0]  bad_cnt_reg, bad_cnt_next;
    logic        in_frame_reg, in_frame_next;
    logic [31:0] prev_reg, prev_next;
    logic        err_reg, err_next;

    logic [31:0] exp_word;
    logic [31:0] chk_mask;
    logic        checked;
    logic        word_err;
    logic        full_beat;

    assign exp_word  = prbs31_step32(prev_reg);
    assign chk_mask  = rx_last_i ? lane_mask(rx_vldb_i) : 32'hFFFF_FFFF;
    assign full_beat = !rx_last_i || (rx_vldb_i == 2'd3);
    assign checked   = rx_valid_i && in_frame_reg;
    assign word_err  = |((exp_word ^ rx_data_i) & chk_mask);

    // Frame tracking and predictor seed. A partial last beat is still checked
    // but is not a usable seed, which is harmless since the frame ends there.
    always_comb begin
        in_frame_next = in_frame_reg;
        prev_next     = prev_reg;
        if (rx_valid_i) begin
            if (!in_frame_reg) begin
                prev_next     = rx_data_i;
                in_frame_next = !rx_last_i;
            end else begin
                if (full_beat) begin
                    prev_next = rx_data_i;
                end
                if (rx_last_i) begin
                    in_frame_next = 1'b0;
                end
            end
        end
    end

    // Lock FSM; only checked words move it.
    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        err_next      = 1'b0;
        if (checked) begin
            case (state_reg)
                HUNT: begin
                    if (word_err) begin
                        good_cnt_next = '0;
                    end else if (good_cnt_reg == 8'(LOCK_GOOD - 1)) begin
                        state_next    = LOCKED;
                        good_cnt_next = '0;
                    end else begin
                        good_cnt_next = good_cnt_reg + 8'd1;
                    end
                end
                LOCKED: begin
                    err_next = word_err;
                    if (!word_err) begin
                        bad_cnt_next = '0;
                    end else if (bad_cnt_reg == 4'(LOSS_BAD - 1)) begin
                        state_next   = HUNT;
                        bad_cnt_next = '0;
                    end else begin
                        bad_cnt_next = bad_cnt_reg + 4'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge rx_user_clk_i) begin
        if (rx_user_rst_i) begin
            state_reg    <= HUNT;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            in_frame_reg <= 1'b0;
            prev_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
            in_frame_reg <= in_frame_next;
            prev_reg     <= prev_next;
            err_reg      <= err_next;
        end
    end

    assign lock_o = (state_reg == LOCKED);
    assign err_o  = err_reg;

    // Counter increments use the state the beat was received in, so the word
    // that causes loss of lock is still counted.
    logic [2:0]  inc32;
    logic [31:0] cnt32 [3];
    logic        bad_frame_inc;

    assign inc32[0]      = rx_valid_i && rx_last_i && (state_reg == LOCKED);
    assign inc32[1]      = checked && (state_reg == LOCKED);
    assign inc32[2]      = checked && (state_reg == LOCKED) && word_err;
    assign bad_frame_inc = rx_valid_i && rx_last_i && rx_user_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt32
            sat_counter #(.W(32)) u_cnt (
                .clk  (rx_user_clk_i),
                .srst (rx_user_rst_i),
                .inc  (inc32[gi]),
                .clr  (clear_i),
                .q    (cnt32[gi])
            );
        end
    endgenerate

    sat_counter #(.W(16)) u_bad_frame_cnt (
        .clk  (rx_user_clk_i),
        .srst (rx_user_rst_i),
        .inc  (bad_frame_inc),
        .clr  (clear_i),
        .q    (bad_frame_cnt_o)
    );

    assign frame_cnt_o    = cnt32[0];
    assign word_cnt_o     = cnt32[1];
    assign err_word_cnt_o = cnt32[2];

endmodule

// File: tb/tb_prbs_rx_monitor.sv
// tb_prbs_rx_monitor: scoreboard bench for prbs_rx_monitor. The driver pushes
// the expected post-beat outputs (from a bit-serial reference LFSR and a
// behavioural lock/counter model) tagged with the cycle they must appear in;
// a negedge monitor pops and compares. Directed checks add hand-computed values.
module tb_prbs_rx_monitor;

    localparam int LOCK_GOOD = 16;
    localparam int LOSS_BAD  = 4;

    logic        clk = 1'b0;
    logic        rx_user_rst_i = 1'b0;
    logic [31:0] rx_data_i = '0;
    logic [1:0]  rx_vldb_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_last_i = 1'b0;
    logic        rx_user_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        lock_o, err_o;
    logic [31:0] frame_cnt_o, word_cnt_o, err_word_cnt_o;
    logic [15:0] bad_frame_cnt_o;

    logic        sat_srst = 1'b0, sat_inc = 1'b0, sat_clr = 1'b0;
    logic [2:0]  sat_q;

    always #5 clk = ~clk;

    prbs_rx_monitor #(.LOCK_GOOD(LOCK_GOOD), .LOSS_BAD(LOSS_BAD)) dut (
        .rx_user_clk_i   (clk),
        .rx_user_rst_i   (rx_user_rst_i),
        .rx_data_i       (rx_data_i),
        .rx_vldb_i       (rx_vldb_i),
        .rx_valid_i      (rx_valid_i),
        .rx_last_i       (rx_last_i),
        .rx_user_i       (rx_user_i),
        .clear_i         (clear_i),
        .lock_o          (lock_o),
        .err_o           (err_o),
        .frame_cnt_o     (frame_cnt_o),
        .word_cnt_o      (word_cnt_o),
        .err_word_cnt_o  (err_word_cnt_o),
        .bad_frame_cnt_o (bad_frame_cnt_o)
    );

    // Narrow instance so saturation at all-ones is reachable in a few cycles.
    sat_counter #(.W(3)) u_sat (
        .clk  (clk),
        .srst (sat_srst),
        .inc  (sat_inc),
        .clr  (sat_clr),
        .q    (sat_q)
    );

    typedef struct {
        int unsigned cyc;
        logic        lock;
        logic        err;
        logic [31:0] frame;
        logic [31:0] word;
        logic [31:0] errw;
        logic [15:0] badf;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    logic        m_lock = 1'b0, m_in_frame = 1'b0;
    int          m_good = 0, m_bad = 0;
    logic [31:0] m_prev = '0;
    logic [31:0] m_frame = '0, m_word = '0, m_errw = '0;
    logic [15:0] m_badf = '0;
    logic [31:0] gw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Bit-serial LFSR: shift register holds the last 31 stream bits.
    function automatic logic [31:0] ref_next(input logic [31:0] w);
        logic [30:0] st;
        logic        nb;
        logic [31:0] o;
        st = w[30:0];
        o  = '0;
        for (int i = 0; i < 32; i++) begin
            nb = st[30] ^ st[27];
            st = {st[29:0], nb};
            o  = {o[30:0], nb};
        end
        return o;
    endfunction

    task automatic model(input logic v, input logic [31:0] d, input logic [1:0] vb,
                         input logic l, input logic u, input logic c, input logic r,
                         output logic err_out);
        logic        lock_pre, bad, f_inc, w_inc, e_inc, b_inc;
        logic [31:0] mask;
        int          nl;
        err_out = 1'b0;
        f_inc = 0; w_inc = 0; e_inc = 0; b_inc = 0;
        if (r) begin
            m_lock = 0; m_in_frame = 0; m_good = 0; m_bad = 0; m_prev = '0;
            m_frame = '0; m_word = '0; m_errw = '0; m_badf = '0;
            return;
        end
        if (v) begin
            lock_pre = m_lock;
            f_inc = l && lock_pre;
            b_inc = l && u;
            if (!m_in_frame) begin
                m_prev = d;
                m_in_frame = !l;
            end else begin
                nl = l ? int'(vb) + 1 : 4;
                mask = '0;
                for (int k = 0; k < nl; k++) mask[8*k +: 8] = 8'hFF;
                bad = ((ref_next(m_prev) ^ d) & mask) != 0;
                if (nl == 4) m_prev = d;
                if (l) m_in_frame = 0;
                if (lock_pre) begin
                    w_inc = 1;
                    if (bad) begin
                        e_inc = 1; err_out = 1; m_bad++;
                        if (m_bad == LOSS_BAD) begin m_lock = 0; m_bad = 0; end
                    end else m_bad = 0;
                end else begin
                    if (bad) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == LOCK_GOOD) begin m_lock = 1; m_good = 0; end
                    end
                end
            end
        end
        if (c) begin
            m_frame = '0; m_word = '0; m_errw = '0; m_badf = '0;
        end else begin
            if (f_inc && m_frame != 32'hFFFF_FFFF) m_frame++;
            if (w_inc && m_word  != 32'hFFFF_FFFF) m_word++;
            if (e_inc && m_errw  != 32'hFFFF_FFFF) m_errw++;
            if (b_inc && m_badf  != 16'hFFFF)      m_badf++;
        end
    endtask

    // One driven cycle: inputs set at negedge, sampled at posedge, released #1 later.
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] vb,
                        input logic l, input logic u, input logic c, input logic r);
        logic e_err;
        exp_t e;
        @(negedge clk);
        rx_valid_i = v; rx_data_i = d; rx_vldb_i = vb; rx_last_i = l;
        rx_user_i = u; clear_i = c; rx_user_rst_i = r;
        model(v, d, vb, l, u, c, r, e_err);
        e.cyc = cyc + 1; e.lock = m_lock; e.err = e_err;
        e.frame = m_frame; e.word = m_word; e.errw = m_errw; e.badf = m_badf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rx_valid_i = 0; rx_last_i = 0; rx_user_i = 0; clear_i = 0; rx_user_rst_i = 0;
    endtask

    task automatic beat(input logic [31:0] flip, input logic last, input logic [1:0] vb);
        step(1'b1, gw ^ flip, vb, last, 1'b0, 1'b0, 1'b0);
        gw = ref_next(gw);
    endtask

    task automatic frame(input int n, input int cf, input int cl, input logic [31:0] flip);
        for (int i = 0; i < n; i++) beat((i >= cf && i <= cl) ? flip : 32'h0, i == n - 1, 2'd3);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            $display("cyc %0d: lock=%0b err=%0b frame=%0d word=%0d errw=%0d badf=%0d",
                     cyc, lock_o, err_o, frame_cnt_o, word_cnt_o, err_word_cnt_o, bad_frame_cnt_o);
            check("sb_lock",  {31'b0, lock_o}, {31'b0, e.lock});
            check("sb_err",   {31'b0, err_o},  {31'b0, e.err});
            check("sb_frame", frame_cnt_o,     e.frame);
            check("sb_word",  word_cnt_o,      e.word);
            check("sb_errw",  err_word_cnt_o,  e.errw);
            check("sb_badf",  {16'b0, bad_frame_cnt_o}, {16'b0, e.badf});
        end
    end

    initial begin
        gw = 32'h0000_0001;
        step(0, 0, 0, 0, 0, 0, 1);
        check("rst_lock", {31'b0, lock_o}, 32'd0);
        check("rst_word", word_cnt_o, 32'd0);

        // Acquire lock: 16th good checked word is frame 3, beat 2.
        frame(8, -1, -2, 0);
        frame(8, -1, -2, 0);
        for (int i = 0; i < 8; i++) begin
            beat(0, i == 7, 2'd3);
            if (i == 1) check("lock_before_16th", {31'b0, lock_o}, 32'd0);
            if (i == 2) check("lock_at_16th", {31'b0, lock_o}, 32'd1);
        end
        frame(8, -1, -2, 0);
        check("acq_word",  word_cnt_o, 32'd12);
        check("acq_frame", frame_cnt_o, 32'd2);
        check("acq_errw",  err_word_cnt_o, 32'd0);

        // Single bit flip: two errored words, lock held.
        for (int i = 0; i < 8; i++) begin
            beat((i == 3) ? 32'h1 : 32'h0, i == 7, 2'd3);
            if (i == 3) check("flip_err_pulse", {31'b0, err_o}, 32'd1);
        end
        check("flip_errw", err_word_cnt_o, 32'd2);
        check("flip_lock", {31'b0, lock_o}, 32'd1);

        // Four consecutive corrupted words: lock lost after the 4th.
        for (int i = 0; i < 8; i++) begin
            beat((i >= 2 && i <= 5) ? 32'h8000_0001 : 32'h0, i == 7, 2'd3);
            if (i == 4) check("loss_lock_held", {31'b0, lock_o}, 32'd1);
            if (i == 5) check("loss_lock_drop", {31'b0, lock_o}, 32'd0);
        end
        check("loss_errw", err_word_cnt_o, 32'd6);
        for (int f = 0; f < 3; f++) frame(8, -1, -2, 0);
        check("relock", {31'b0, lock_o}, 32'd1);

        // Partial last beat: invalid lane ignored, valid lane checked.
        for (int i = 0; i < 3; i++) beat(0, 0, 2'd3);
        beat(32'hFF00_0000, 1, 2'd1);
        check("vldb_byte3_err", {31'b0, err_o}, 32'd0);
        for (int i = 0; i < 3; i++) beat(0, 0, 2'd3);
        beat(32'h0000_FF00, 1, 2'd1);
        check("vldb_byte1_err", {31'b0, err_o}, 32'd1);
        check("vldb_errw", err_word_cnt_o, 32'd7);
        gw = 32'hDEAD_BEEF;
        beat(0, 0, 2'd3);
        check("first_beat_err", {31'b0, err_o}, 32'd0);
        frame(7, -1, -2, 0);
        check("reseed_errw", err_word_cnt_o, 32'd7);

        // Reset mid-frame while locked.
        for (int i = 0; i < 3; i++) beat(0, 0, 2'd3);
        step(0, 0, 0, 0, 0, 0, 1);
        check("midrst_lock", {31'b0, lock_o}, 32'd0);
        check("midrst_frame", frame_cnt_o, 32'd0);
        check("midrst_errw", err_word_cnt_o, 32'd0);
        gw = 32'h1234_5678;
        beat(32'h0F0F_0000, 0, 2'd3);
        check("post_rst_first_err", {31'b0, err_o}, 32'd0);
        frame(3, -1, -2, 0);

        // Bad frame in HUNT, then clear colliding with an increment.
        step(1, 32'hA5A5_A5A5, 2'd3, 1, 1, 0, 0);
        check("badf_one", {16'b0, bad_frame_cnt_o}, 32'd1);
        check("badf_frame", frame_cnt_o, 32'd0);
        step(1, 32'h5A5A_5A5A, 2'd3, 1, 1, 1, 0);
        check("clr_badf", {16'b0, bad_frame_cnt_o}, 32'd0);
        check("clr_word", word_cnt_o, 32'd0);

        // Saturation on the narrow counter instance: 6 -> two more -> 7.
        @(negedge clk); sat_srst = 1;
        @(negedge clk); sat_srst = 0; sat_inc = 1;
        repeat (5) @(negedge clk);
        @(negedge clk); sat_inc = 0;
        check("sat_pre", {29'b0, sat_q}, 32'd6);
        sat_inc = 1;
        repeat (2) @(negedge clk);
        sat_inc = 0;
        check("sat_hold", {29'b0, sat_q}, 32'd7);
        sat_inc = 1; sat_clr = 1;
        @(negedge clk);
        sat_inc = 0; sat_clr = 0;
        check("sat_clr", {29'b0, sat_q}, 32'd0);

        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_rx_monitor.md
# prbs_rx_monitor

Frame-aware PRBS31 receive monitor on the MAC RX AXIS user interface of `xm_top`. It sits downstream of the RX path, alongside the existing checker on the same `rx_*` stream. Per frame, it reseeds a 32-bit-parallel PRBS31 predictor from received data and runs a HUNT/LOCKED state machine. It keeps saturating frame, word, errored-word and bad-frame counters for link bring-up and soak tests.

## Interface
- `LOCK_GOOD`, 16: consecutive good checked words needed to go HUNT→LOCKED (1..255).
- `LOSS_BAD`, 4: consecutive errored checked words needed to go LOCKED→HUNT (1..15).
- `rx_user_clk_i`  in  1  RX user clock; the only clock.
- `rx_user_rst_i`  in  1  reset, synchronous, active-high.
- `rx_data_i`  in  32  beat data; byte k = bits [8k+7:8k].
- `rx_vldb_i`  in  2  on a last beat: valid bytes minus 1, lanes 0..vldb valid; ignored on other beats (all 4 lanes valid).
- `rx_valid_i`  in  1  beat qualifier; no backpressure, every valid beat is consumed.
- `rx_last_i`  in  1  last beat of frame.
- `rx_user_i`  in  1  on a last beat: 1 = frame marked bad by MAC.
- `clear_i`  in  1  synchronous counter clear; does not touch lock state.
- `lock_o`  out  1  1 in LOCKED.
- `err_o`  out  1  one-cycle pulse per errored checked word while LOCKED.
- `frame_cnt_o`  out  32  frames ended (last beats) while LOCKED.
- `word_cnt_o`  out  32  checked words while LOCKED.
- `err_word_cnt_o`  out  32  errored checked words while LOCKED.
- `bad_frame_cnt_o`  out  16  last beats with `rx_user_i`=1, in any state.

## Operation
- Predictor: PRBS31, x^31+x^28+1, 32 bits per beat, MSB-first. `exp = prbs31_step32(prev)`, where `prev` is the previous full received word of the same frame.
- First beat of every frame: not checked. Loads `prev`; sets `in_frame`.
- Later beats are checked words:
  - Mismatch = any differing bit in valid lanes.
  - A checked beat updates `prev` only when all 4 lanes are valid.
- A single-beat frame (first beat with `rx_last_i`) has no checked word.
- FSM states, reset → HUNT:
  - HUNT: good checked word increments `good_cnt`; errored word clears it. `good_cnt` reaching `LOCK_GOOD` → LOCKED; clears `good_cnt`.
  - LOCKED: errored word increments `bad_cnt`; good word clears it. `bad_cnt` reaching `LOSS_BAD` → HUNT; clears `bad_cnt`. The word that triggers loss is still counted and still pulses `err_o`.
- Counters saturate at all-ones; no wrap.
- `clear_i` zeroes all four counters next cycle and has priority over a simultaneous increment.
- Reset zeroes every register; all outputs = 0; `in_frame` = 0.
- Reset mid-frame: the next valid beat is treated as a frame first beat.

## Timing
- All outputs are registered.
- `err_o`, counter increments and `lock_o` changes appear 1 cycle after the qualifying beat (`rx_valid_i`=1 sampled).
- Full throughput: back-to-back beats and back-to-back frames (last beat followed immediately by first beat) are supported with no bubbles.
- A `rx_valid_i`=0 gap leaves all state unchanged.
- The step function is a single combinational level into registers. It must close timing at 156.25 MHz.

## Structure
- Package `prbs_pkg`:
  - `PRBS31_TAP_A`=31, `PRBS31_TAP_B`=28.
  - Function `prbs31_step32` (32-bit in → 32-bit next word).
  - Lane-mask function from `vldb`.
  - FSM state enum {HUNT, LOCKED}.
  - Shared with `prbs_gen` so the generator and the monitor cannot diverge.
- One sub-module is natural: `sat_counter` (parameter `W`; inputs `inc`, `clr`; output `q`), instantiated four times.

## Test plan
- Reset, then 4 frames × 8 full beats of correct PRBS31 from seed 32'h0000_0001 → 28 checked words. `lock_o`=1 one cycle after the 16th good checked word. After lock: `word_cnt_o`=12, `frame_cnt_o`=2, `err_word_cnt_o`=0.
- Locked, flip bit 0 of one mid-frame word → `err_o` high exactly one cycle later and `err_word_cnt_o`+1.
  - The following word is also errored (predicted from the bad `prev`), so `err_word_cnt_o`=2 in total.
  - `lock_o` stays 1.
- Locked, 4 consecutive corrupted words → `lock_o`=0 one cycle after the 4th; `err_word_cnt_o`+4. Then 16 good checked words → `lock_o`=1.
- Last beat with `rx_vldb_i`=1 and corruption only in byte 3 → no error.
  - Corruption in byte 1 → error.
  - Next frame's first beat → never flagged.
- `rx_user_i`=1 on a last beat in HUNT → `bad_frame_cnt_o`=1, `frame_cnt_o` unchanged.
  - `clear_i` coincident with an increment → all counters 0.
- Preload `err_word_cnt_o` to 32'hFFFF_FFFE via forced errors or a test hook. Two more errors → holds at 32'hFFFF_FFFF.
- Assert `rx_user_rst_i` mid-frame while locked → all outputs 0 next cycle. The next beat is treated as a first beat, so no error.
